// File: rtl/uart_rx_deserializer.sv
// UART receive engine: recovers LSB-first frames from the pad rxd and presents bytes on valid/ready.
// Optional parity bit after the data bits is enabled with `define UART_RX_PARITY_EN.
module uart_rx_deserializer #(
    parameter int DIV_W       = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 io_uart_rxd,
    input  logic [DIV_W-1:0]     div,
    input  logic                 parity_odd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_q, frame_d;
    logic                   over_q, over_d;
    logic                   rxd_s;
    logic                   tick;
    logic                   pop;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic par_err_q, par_err_d;
`endif

    assign rxd_s = sync_q[SYNC_STAGES-1];
    assign tick  = (cnt_q == '0);
    assign pop   = valid_q && out_ready;

    // Synchroniser resets to the idle-line level so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_uart_rxd};
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = valid_q && !pop;
        frame_d  = 1'b0;
        over_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_err_d = 1'b0;
`endif

        if (state_q == ST_IDLE && !rxd_s) begin
            cnt_d = div >> 1;
        end else if (tick) begin
            cnt_d = div;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxd_s) state_d = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    if (!rxd_s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    par_bad_d = ((^shreg_q) ^ rxd_s) != parity_odd;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Decided at mid stop bit; the result lands in the registers on this edge.
                if (tick) begin
                    state_d = ST_IDLE;
                    if (!rxd_s) begin
                        frame_d = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end
`endif
                    else if (!valid_q || pop) begin
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                    end else begin
                        over_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            over_q  <= over_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_bad_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            par_err_q <= par_err_d;
        end
    end

    assign parity_err = par_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_err   = frame_q;
    assign overrun_err = over_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frame table plus latency, glitch, overrun,
// handshake-race, mid-frame reset and (with UART_RX_PARITY_EN) parity sequences.
module tb_uart_rx_deserializer;

    localparam int DIV_W     = 16;
    localparam int DATA_BITS = 8;
    localparam int SYNC_LAT  = 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                 clock       = 1'b0;
    logic                 reset_n     = 1'b0;
    logic                 io_uart_rxd = 1'b1;
    logic [DIV_W-1:0]     div         = 16'd15;
    logic                 parity_odd  = 1'b0;
    logic                 out_ready   = 1'b0;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic                 busy;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 parity_err;

    uart_rx_deserializer #(
        .DIV_W      (DIV_W),
        .DATA_BITS  (DATA_BITS),
        .SYNC_STAGES(SYNC_LAT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .io_uart_rxd(io_uart_rxd),
        .div        (div),
        .parity_odd (parity_odd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Event monitor, sampled mid-cycle on the falling edge.
    int         n_acc = 0, n_frame = 0, n_over = 0, n_par = 0, rise_cyc = -1;
    logic [7:0] acc_data = 8'h00;
    logic       prev_valid = 1'b0;
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            n_acc++;
            acc_data = out_data;
        end
        if (frame_err)   n_frame++;
        if (overrun_err) n_over++;
        if (parity_err)  n_par++;
        if (out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = out_valid;
    end

    int total = 0, bad = 0;
    int b_acc, b_frame, b_over, b_par;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic snap();
        b_acc = n_acc; b_frame = n_frame; b_over = n_over; b_par = n_par;
    endtask

    task automatic hold(input logic b);
        io_uart_rxd = b;
        repeat (int'(div) + 1) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pb);
        hold(1'b0);
        for (int i = 0; i < DATA_BITS; i++) hold(d[i]);
        if (PAR_EN) hold(pb);
        hold(stop_b);
        io_uart_rxd = 1'b1;
    endtask

    // Parity bit that satisfies XOR(data, parity_bit) == parity_odd.
    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ parity_odd;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        int         exp_acc;
        logic [7:0] exp_data;
        int         exp_frame;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int lat;

        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
        vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[4] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[5] = '{8'h5A, 1'b0, 0, 8'h00, 1};
        lat = SYNC_LAT + 8 + 1 + 9 * 16 + (PAR_EN ? 16 : 0);

        // Reset state
        repeat (3) step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_errs", {frame_err, overrun_err, parity_err}, 3'b000);
        reset_n = 1'b1;
        repeat (5) step();

        // Latency of a clean 0xA5 frame from the pin falling edge
        out_ready = 1'b1;
        snap();
        s = cyc;
        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        repeat (20) step();
        check("lat_rise", rise_cyc - s, lat);
        check("lat_acc", n_acc - b_acc, 1);
        check("lat_data", acc_data, 8'hA5);
        check("lat_errs", (n_frame - b_frame) + (n_over - b_over) + (n_par - b_par), 0);
        check("lat_valid_drop", out_valid, 0);

        // Table of frames, consumer always ready
        for (int i = 0; i < 6; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].stop_b, good_par(vecs[i].data));
            repeat (40) step();
            check($sformatf("vec%0d_acc", i), n_acc - b_acc, vecs[i].exp_acc);
            check($sformatf("vec%0d_frame", i), n_frame - b_frame, vecs[i].exp_frame);
            check($sformatf("vec%0d_over", i), n_over - b_over, 0);
            check($sformatf("vec%0d_par", i), n_par - b_par, 0);
            check($sformatf("vec%0d_busy", i), busy, 0);
            if (vecs[i].exp_acc != 0) check($sformatf("vec%0d_data", i), acc_data, vecs[i].exp_data);
        end

        // Short low glitch on the line is rejected at the start tick
        snap();
        io_uart_rxd = 1'b0;
        repeat (4) step();
        io_uart_rxd = 1'b1;
        step();
        check("glitch_busy_hi", busy, 1);
        repeat (7) step();
        check("glitch_busy_lo", busy, 0);
        repeat (30) step();
        check("glitch_none", (n_acc - b_acc) + (n_frame - b_frame) + (n_over - b_over), 0);

        // Overrun: consumer stalled, second byte dropped, first retained
        out_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, good_par(8'h11));
        repeat (4) step();
        send_frame(8'h22, 1'b1, good_par(8'h22));
        repeat (20) step();
        check("ovr_valid", out_valid, 1);
        check("ovr_data", out_data, 8'h11);
        check("ovr_pulse", n_over - b_over, 1);
        check("ovr_frame", n_frame - b_frame, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check("ovr_pop_acc", n_acc - b_acc, 1);
        check("ovr_pop_data", acc_data, 8'h11);
        check("ovr_pop_valid", out_valid, 0);

        // Pop on the exact load cycle of the next byte: load wins, no overrun
        snap();
        send_frame(8'h33, 1'b1, good_par(8'h33));
        repeat (10) step();
        s = cyc;
        fork
            send_frame(8'h22, 1'b1, good_par(8'h22));
            begin
                repeat (lat - 1) step();
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end
        join
        repeat (10) step();
        check("race_valid", out_valid, 1);
        check("race_data", out_data, 8'h22);
        check("race_over", n_over - b_over, 0);
        check("race_acc", n_acc - b_acc, 1);
        check("race_pop_data", acc_data, 8'h33);

        // Reset asserted during data bit 4 aborts the frame silently
        snap();
        fork
            send_frame(8'hF3, 1'b1, 1'b1);
            begin
                repeat (SYNC_LAT + 16 * 5 + 8) step();
                reset_n = 1'b0;
                step();
                check("mrst_valid", out_valid, 0);
                check("mrst_data", out_data, 8'h00);
                check("mrst_busy", busy, 0);
                check("mrst_errs", {frame_err, overrun_err, parity_err}, 3'b000);
                step();
                reset_n = 1'b1;
            end
        join
        repeat (30) step();
        check("mrst_after_busy", busy, 0);
        check("mrst_after_evts", (n_frame - b_frame) + (n_over - b_over) + (n_par - b_par), 0);
        check("mrst_after_valid", out_valid, 0);
        out_ready = 1'b1;
        snap();
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        repeat (20) step();
        check("mrst_next_acc", n_acc - b_acc, 1);
        check("mrst_next_data", acc_data, 8'h5A);

`ifdef UART_RX_PARITY_EN
        // Odd parity: 0x07 has three ones, so parity bit 1 is wrong and 0 is right
        parity_odd = 1'b1;
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (20) step();
        check("par_bad_pulse", n_par - b_par, 1);
        check("par_bad_acc", n_acc - b_acc, 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (20) step();
        check("par_ok_pulse", n_par - b_par, 0);
        check("par_ok_acc", n_acc - b_acc, 1);
        check("par_ok_data", acc_data, 8'h07);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
